// File: rtl/vector_exec_unit_if.sv
// Bus bundle for vector_exec_unit: the operation request/response handshake
// from the control FSM and the single-port data memory port.
//   master : control/memory side (drives start, op, sat, base, vsrc1, vsrc2, mem_q)
//   slave  : execution unit side (drives ready, done, vresult, lane_cf, vz,
//            mem_addr, mem_wren, mem_wdata)
interface vector_exec_unit_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 8
);
  logic                   start;
  logic [1:0]             op;
  logic                   sat;
  logic [AW-1:0]          base;
  logic [LANES*WIDTH-1:0] vsrc1;
  logic [LANES*WIDTH-1:0] vsrc2;
  logic                   ready;
  logic                   done;
  logic [LANES*WIDTH-1:0] vresult;
  logic [LANES-1:0]       lane_cf;
  logic                   vz;
  logic [AW-1:0]          mem_addr;
  logic                   mem_wren;
  logic [WIDTH-1:0]       mem_wdata;
  logic [WIDTH-1:0]       mem_q;

  modport master (
    output start, op, sat, base, vsrc1, vsrc2, mem_q,
    input  ready, done, vresult, lane_cf, vz, mem_addr, mem_wren, mem_wdata
  );

  modport slave (
    input  start, op, sat, base, vsrc1, vsrc2, mem_q,
    output ready, done, vresult, lane_cf, vz, mem_addr, mem_wren, mem_wdata
  );
endinterface

// File: rtl/vector_exec_unit.sv
// Vector execution unit: VLOAD / VSTORE / lane-wise VADD / VSUB on a
// LANES x WIDTH vector, sequencing one memory lane per cycle.
// Ports:
//   clock  - clock
//   reset  - asynchronous, active-high reset
//   bus    - vector_exec_unit_if.slave: start/op/sat/base/vsrc1/vsrc2 request,
//            ready/done/vresult/lane_cf/vz response, mem_addr/mem_wren/
//            mem_wdata/mem_q synchronous-RAM port (q valid one cycle after addr).
// Lane i occupies bits [(LANES-i)*WIDTH-1 -: WIDTH] (lane 0 is the MSB slice);
// lane_cf lane i is bit LANES-1-i.
module vector_exec_unit #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic               clock,
  input  logic               reset,
  vector_exec_unit_if.slave  bus
);
  localparam int CW = AW + 1;
  localparam int VW = LANES * WIDTH;
  localparam logic [CW-1:0] LAST      = CW'(LANES);
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_STORE = 3'd2;
  localparam logic [2:0] S_ALU   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    i;
  logic [1:0]       op_r;
  logic             sat_r;
  logic [AW-1:0]    base_r;
  logic [VW-1:0]    a_r;
  logic [VW-1:0]    b_r;
  logic [VW-1:0]    vresult_r;
  logic [LANES-1:0] cf_r;
  logic             vz_r;

  logic [VW-1:0]    alu_res;
  logic [LANES-1:0] alu_cf;
  logic [WIDTH-1:0] lane_a;
  logic [WIDTH-1:0] lane_b;
  logic [WIDTH:0]   lane_r;

  // Per-lane (WIDTH+1)-bit add/sub; the top bit is carry-out for ADD and
  // borrow (a<b) for SUB, and also selects the saturation clamp.
  always_comb begin
    alu_res = '0;
    alu_cf  = '0;
    lane_a  = '0;
    lane_b  = '0;
    lane_r  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_a = a_r[(LANES-1-l)*WIDTH +: WIDTH];
      lane_b = b_r[(LANES-1-l)*WIDTH +: WIDTH];
      if (op_r[0]) lane_r = {1'b0, lane_a} - {1'b0, lane_b};
      else         lane_r = {1'b0, lane_a} + {1'b0, lane_b};
      alu_cf[LANES-1-l] = lane_r[WIDTH];
      if (sat_r && lane_r[WIDTH])
        alu_res[(LANES-1-l)*WIDTH +: WIDTH] = op_r[0] ? '0 : '1;
      else
        alu_res[(LANES-1-l)*WIDTH +: WIDTH] = lane_r[WIDTH-1:0];
    end
  end

  // Memory port is purely a function of state so reset drops mem_wren at once.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wren  = (state == S_STORE);
    if ((state == S_LOAD && i < LAST) || state == S_STORE)
      bus.mem_addr = base_r + i[AW-1:0];
    if (state == S_STORE) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (i == CW'(l)) bus.mem_wdata = a_r[(LANES-1-l)*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    bus.ready   = (state == S_IDLE);
    bus.done    = (state == S_DONE);
    bus.vresult = vresult_r;
    bus.lane_cf = cf_r;
    bus.vz      = vz_r;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      i         <= '0;
      op_r      <= '0;
      sat_r     <= 1'b0;
      base_r    <= '0;
      a_r       <= '0;
      b_r       <= '0;
      vresult_r <= '0;
      cf_r      <= '0;
      vz_r      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_r   <= bus.op;
            sat_r  <= bus.sat;
            base_r <= bus.base;
            a_r    <= bus.vsrc1;
            b_r    <= bus.vsrc2;
            i      <= '0;
            case (bus.op)
              2'b00:   state <= S_LOAD;
              2'b01:   state <= S_STORE;
              default: state <= S_ALU;
            endcase
          end
        end
        S_LOAD: begin
          // mem_q lags its address by one cycle, so lane i-1 lands while i is driven.
          i <= i + 1'b1;
          for (int unsigned l = 0; l < LANES; l++) begin
            if (i == CW'(l + 1)) vresult_r[(LANES-1-l)*WIDTH +: WIDTH] <= bus.mem_q;
          end
          if (i == LAST) state <= S_DONE;
        end
        S_STORE: begin
          i <= i + 1'b1;
          if (i == LAST_LANE) state <= S_DONE;
        end
        S_ALU: begin
          vresult_r <= alu_res;
          cf_r      <= alu_cf;
          vz_r      <= ~|alu_res;
          state     <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_exec_unit.sv
// Self-checking bench for vector_exec_unit (LANES=4, WIDTH=8, AW=8) with a
// synchronous RAM model on the memory port and a timeline model of the
// expected outputs, plus literal expectations from hand-computed vectors.
module tb_vector_exec_unit;
  localparam int L   = 4;
  localparam int W   = 8;
  localparam int AWD = 8;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  vector_exec_unit_if #(.LANES(L), .WIDTH(W), .AW(AWD)) bus ();

  vector_exec_unit #(.LANES(L), .WIDTH(W), .AW(AWD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous single-port RAM seen by the DUT.
  logic [7:0] dut_mem [256];
  logic [7:0] q_r;
  always @(posedge clock) begin
    if (bus.mem_wren) dut_mem[bus.mem_addr] <= bus.mem_wdata;
    q_r <= dut_mem[bus.mem_addr];
  end
  assign bus.mem_q = q_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lane_of(input logic [31:0] v, input int j);
    return v[(L-1-j)*W +: W];
  endfunction

  function automatic int dur_of(input logic [1:0] op);
    if (op == 2'b00) return L + 1;
    if (op == 2'b01) return L;
    return 1;
  endfunction

  function automatic logic [31:0] alu_vec(input logic [1:0] op, input logic sat,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    int x, y, r;
    res = '0;
    for (int j = 0; j < L; j++) begin
      x = int'(lane_of(a, j));
      y = int'(lane_of(b, j));
      if (op == 2'b10) begin
        r = x + y;
        if (r > 255) r = sat ? 255 : r - 256;
      end else begin
        r = x - y;
        if (r < 0) r = sat ? 0 : r + 256;
      end
      res[(L-1-j)*W +: W] = 8'(r);
    end
    return res;
  endfunction

  function automatic logic [3:0] alu_cfv(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [3:0] cf;
    int x, y;
    cf = '0;
    for (int j = 0; j < L; j++) begin
      x = int'(lane_of(a, j));
      y = int'(lane_of(b, j));
      cf[L-1-j] = (op == 2'b10) ? (x + y > 255) : (x < y);
    end
    return cf;
  endfunction

  // Timeline model: m_k = edges since acceptance minus one.
  logic        m_busy;
  int          m_k;
  logic [1:0]  m_op;
  logic        m_sat;
  logic [7:0]  m_base;
  logic [31:0] m_a, m_b;
  logic [31:0] exp_vresult;
  logic [3:0]  exp_cf;
  logic        exp_vz;
  logic [7:0]  refmem [256];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy      <= 1'b0;
      m_k         <= 0;
      exp_vresult <= '0;
      exp_cf      <= '0;
      exp_vz      <= 1'b0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy <= 1'b1;
        m_k    <= 0;
        m_op   <= bus.op;
        m_sat  <= bus.sat;
        m_base <= bus.base;
        m_a    <= bus.vsrc1;
        m_b    <= bus.vsrc2;
      end
    end else begin
      m_k <= m_k + 1;
      if (m_k == dur_of(m_op)) m_busy <= 1'b0;
      if (m_op == 2'b00 && m_k >= 1 && m_k <= L)
        exp_vresult[(L-m_k)*W +: W] <= refmem[8'(m_base + m_k - 1)];
      if (m_op == 2'b01 && m_k < L)
        refmem[8'(m_base + m_k)] <= lane_of(m_a, m_k);
      if (m_op[1] && m_k == 0) begin
        exp_vresult <= alu_vec(m_op, m_sat, m_a, m_b);
        exp_cf      <= alu_cfv(m_op, m_a, m_b);
        exp_vz      <= (alu_vec(m_op, m_sat, m_a, m_b) == 32'h0);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      logic       e_wren;
      logic [7:0] e_addr;
      e_wren = m_busy && m_op == 2'b01 && m_k < L;
      e_addr = (m_busy && !m_op[1] && m_k < L) ? 8'(m_base + m_k) : 8'h00;
      chk("ready",     32'(bus.ready),     32'(!m_busy));
      chk("done",      32'(bus.done),      32'(m_busy && m_k == dur_of(m_op)));
      chk("vresult",   bus.vresult,        exp_vresult);
      chk("lane_cf",   32'(bus.lane_cf),   32'(exp_cf));
      chk("vz",        32'(bus.vz),        32'(exp_vz));
      chk("mem_wren",  32'(bus.mem_wren),  32'(e_wren));
      chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wren ? lane_of(m_a, m_k) : 8'h00));
    end
  end

  int first_done, n_done, n_wren;

  task automatic run_op(input logic [1:0] op, input logic sat, input logic [7:0] base,
                        input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic seen_ready;
    @(negedge clock);
    bus.start = 1'b1; bus.op = op; bus.sat = sat; bus.base = base;
    bus.vsrc1 = a;    bus.vsrc2 = b;
    @(posedge clock);
    #1 bus.start = 1'b0;
    first_done = -1; n_done = 0; n_wren = 0; seen_ready = 1'b0;
    for (int k = 0; k < 40 && !seen_ready; k++) begin
      @(negedge clock);
      if (bus.done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (bus.mem_wren) n_wren++;
      if (bus.ready) seen_ready = 1'b1;
      if (poke && (k == 1 || k == 3)) begin
        bus.start = 1'b1; bus.op = 2'b10;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("op_complete", 32'(seen_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},   32'(bus.ready),     32'd1);
    chk({tag, "_done"},    32'(bus.done),      32'd0);
    chk({tag, "_vresult"}, bus.vresult,        32'h0);
    chk({tag, "_cf"},      32'(bus.lane_cf),   32'h0);
    chk({tag, "_vz"},      32'(bus.vz),        32'd0);
    chk({tag, "_wren"},    32'(bus.mem_wren),  32'd0);
    chk({tag, "_addr"},    32'(bus.mem_addr),  32'h0);
    chk({tag, "_wdata"},   32'(bus.mem_wdata), 32'h0);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.sat = 1'b0; bus.base = '0;
    bus.vsrc1 = '0;   bus.vsrc2 = '0;
    #7 check_reset_outputs("por");
    @(negedge clock) reset = 1'b0;

    run_op(2'b10, 1'b0, 8'h00, 32'h01FF8010, 32'h010180F0, 1'b0);
    chk("vadd_res",  bus.vresult,      32'h02000000);
    chk("vadd_cf",   32'(bus.lane_cf), 32'b0111);
    chk("vadd_vz",   32'(bus.vz),      32'd0);
    chk("vadd_done_edge", 32'(first_done), 32'd1);
    chk("vadd_done_cnt",  32'(n_done),     32'd1);

    run_op(2'b10, 1'b1, 8'h00, 32'h01FF8010, 32'h010180F0, 1'b0);
    chk("vadds_res", bus.vresult,      32'h02FFFFFF);
    chk("vadds_cf",  32'(bus.lane_cf), 32'b0111);

    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clock) reset = 1'b0;

    run_op(2'b11, 1'b0, 8'h00, 32'h050010FF, 32'h030110FF, 1'b0);
    chk("vsub_res", bus.vresult,      32'h02FF0000);
    chk("vsub_cf",  32'(bus.lane_cf), 32'b0100);

    run_op(2'b11, 1'b1, 8'h00, 32'h050010FF, 32'h030110FF, 1'b0);
    chk("vsubs_res", bus.vresult, 32'h02000000);

    run_op(2'b11, 1'b0, 8'h00, 32'h12345678, 32'h12345678, 1'b0);
    chk("vsub_eq_res", bus.vresult, 32'h0);
    chk("vsub_eq_vz",  32'(bus.vz), 32'd1);

    run_op(2'b01, 1'b0, 8'hFE, 32'hAABBCCDD, 32'h0, 1'b0);
    chk("st_mem_fe", 32'(dut_mem[8'hFE]), 32'hAA);
    chk("st_mem_ff", 32'(dut_mem[8'hFF]), 32'hBB);
    chk("st_mem_00", 32'(dut_mem[8'h00]), 32'hCC);
    chk("st_mem_01", 32'(dut_mem[8'h01]), 32'hDD);
    chk("st_wren_cycles", 32'(n_wren),     32'd4);
    chk("st_done_edge",   32'(first_done), 32'd4);
    chk("st_vz_hold",     32'(bus.vz),     32'd1);

    run_op(2'b00, 1'b0, 8'hFE, 32'h0, 32'h0, 1'b1);
    chk("ld_res",       bus.vresult,     32'hAABBCCDD);
    chk("ld_done_edge", 32'(first_done), 32'd5);
    chk("ld_done_cnt",  32'(n_done),     32'd1);
    chk("ld_vz_hold",   32'(bus.vz),     32'd1);

    run_op(2'b01, 1'b0, 8'h10, 32'h5A5A5A5A, 32'h0, 1'b0);

    @(negedge clock);
    bus.start = 1'b1; bus.op = 2'b01; bus.base = 8'h10; bus.vsrc1 = 32'h11223344;
    @(posedge clock);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1 chk("prst_ready", 32'(bus.ready),    32'd1);
    chk("prst_wren",     32'(bus.mem_wren), 32'd0);
    chk("prst_addr",     32'(bus.mem_addr), 32'h0);
    chk("prst_vresult",  bus.vresult,       32'h0);
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    #1 chk("prst_mem_10", 32'(dut_mem[8'h10]), 32'h11);
    chk("prst_mem_11",    32'(dut_mem[8'h11]), 32'h22);
    chk("prst_mem_12",    32'(dut_mem[8'h12]), 32'h5A);
    chk("prst_mem_13",    32'(dut_mem[8'h13]), 32'h5A);

    run_op(2'b10, 1'b0, 8'h00, 32'h7F017F00, 32'h01FF8000, 1'b0);
    chk("post_vadd_res", bus.vresult,      32'h8000FF00);
    chk("post_vadd_cf",  32'(bus.lane_cf), 32'b0100);
    chk("post_vadd_done_edge", 32'(first_done), 32'd1);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
